display_arbiter: RTL and testbench
==================================

// Module: display_arbiter
// PURPOSE
//  Shares the 4-digit seven-segment display between N_REQ requesters.
//  Each requester presents a 16-bit hex value and a request.
//  The arbiter grants one owner at a time, round-robin, with a guaranteed minimum hold time.
//  It drives the owner's nibbles, registered, onto data1..data4 of the digit scan driver.
//  data1 is the leftmost digit.
// PARAMETERS
//  N_REQ        4     number of requesters (>=2)
//  HOLD_CYCLES  1024  minimum clk cycles an owner keeps the display before preemption (>=1)
//  CNT_W        16    hold counter width; must hold HOLD_CYCLES-1
// PORTS
//  clk       in   1          system clock, all state on posedge
//  rst       in   1          asynchronous, active-high reset
//  req       in   N_REQ      level request per requester
//  val       in   16*N_REQ   value of requester i = val[16*i+15:16*i]
//  gnt       out  N_REQ      one-hot grant, registered; all-zero when idle
//  owner_id  out  2          index of current/last owner, registered
//  busy      out  1          1 while state==OWN
//  data1     out  4          owner val[15:12], registered
//  data2     out  4          owner val[11:8], registered
//  data3     out  4          owner val[7:4], registered
//  data4     out  4          owner val[3:0], registered
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; gnt=0; busy=0; owner_id=0; data1..4=0; hold cnt=0.
//   - RR pointer last=N_REQ-1, so the first search starts at requester 0.
//  States: IDLE, OWN.
//  IDLE:
//   - gnt=0; data1..4 hold their last value.
//   - If any req bit is set at an edge: winner = first set bit searching last+1, last+2, ... (mod N_REQ); last itself is checked last.
//   - At that same edge: gnt=onehot(winner), owner_id=winner, last=winner, data1..4 <= winner's val, cnt <= HOLD_CYCLES-1, state -> OWN.
//   - If no req bit is set: stay in IDLE.
//  OWN, evaluated at every edge in priority order:
//   1. Owner's req=0: gnt<=0, busy<=0, state -> IDLE (voluntary release; hold not required).
//   2. cnt==0 and any other req bit=1: gnt<=0, state -> IDLE (preemption).
//   3. Otherwise: stay in OWN; cnt decrements if nonzero, saturates at 0; data1..4 <= owner's current val.
//  Timing:
//   - Latency req -> gnt is 1 cycle from IDLE.
//   - val -> data is 1 cycle while owning.
//   - Every owner change passes through exactly one IDLE cycle with gnt=0 (no back-to-back grants).
//   - Under contention, an owner holds gnt for exactly HOLD_CYCLES cycles.
//   - A sole requester keeps gnt indefinitely.
//  Boundary cases:
//   - Owner drops req on the same edge cnt reaches 0: rule 1 applies.
//   - Requests arriving while OWN only affect the next arbitration.
//   - A non-owner req pulse shorter than the remaining hold is lost; requesters hold req until gnt.
//   - Reset mid-OWN clears gnt asynchronously, without waiting for a clock edge.
//   - owner_id is undefined-free: it always holds a valid index < N_REQ.
// TESTING
//  T1 Reset:
//   - rst=1 mid-grant -> gnt=0, busy=0, data1..4=0 before the next clk edge.
//  T2 Single request, HOLD=8:
//   - req=0100, val2=16'h1234 -> next cycle gnt=0100, owner_id=2, data1..4=1,2,3,4.
//   - Drop req -> gnt=0 next cycle.
//  T3 Round-robin, HOLD=8:
//   - req=1111 after reset -> gnt 0001 for 8 cycles, 1 idle, then 0010 (8), 1 idle, then 0100, then 1000, then 0001.
//  T4 Sole owner past hold:
//   - req=0010 held for 100 cycles -> gnt=0010 throughout, no idle gaps.
//  T5 Live update:
//   - Owner val changes 16'hABCD -> 16'h00EF -> data1..4 = 0,0,E,F one cycle later.
//  T6 Early release under contention:
//   - Owner 0 drops req at cycle 3 of hold while req1=1 -> gnt=0 next cycle, gnt=0010 the cycle after.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares the 4-digit seven-segment display between N_REQ requesters.
// The minimum hold time protects an owner only from preemption. An owner may always release early.
module display_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   val,
    output logic [N_REQ-1:0]      gnt,
    output logic [1:0]            owner_id,
    output logic                  busy,
    output logic [3:0]            data1,
    output logic [3:0]            data2,
    output logic [3:0]            data3,
    output logic [3:0]            data4
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   last_q, last_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        data_q, data_d;
    logic [N_REQ-1:0]   gnt_d;
    logic               busy_d;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   cand;
    logic [N_REQ-1:0]   others;
    logic [15:0]        val_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_val
        assign val_arr[g] = val[16*g +: 16];
    end

    // The loop runs from farthest to nearest, so the candidate nearest to last+1 wins.
    always_comb begin
        winner = last_q;
        cand   = last_q;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = PTR_W'((int'(last_q) + i) % int'(N_REQ));
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    assign others = req & ~(N_REQ'(1) << owner_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        busy_d  = busy;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (|req) begin
                    state_d = OWN;
                    gnt_d   = N_REQ'(1) << winner;
                    busy_d  = 1'b1;
                    owner_d = winner;
                    last_d  = winner;
                    data_d  = val_arr[winner];
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if ((cnt_q == '0) && (|others)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    data_d = val_arr[owner_q];
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset pointer at N_REQ-1 so the first search starts at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            owner_q <= '0;
            last_q  <= PTR_W'(N_REQ - 1);
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            busy    <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign owner_id = 2'(owner_q);
    assign data1    = data_q[15:12];
    assign data2    = data_q[11:8];
    assign data3    = data_q[7:4];
    assign data4    = data_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: a cycle-level ownership model predicts the outputs,
// and a monitor compares the DUT against each prediction one edge later.
module tb_display_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 8;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic        busy;
        logic [15:0] data;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = '0;
    logic [63:0]  val = '0;
    logic [3:0]   gnt;
    logic [1:0]   owner_id;
    logic         busy;
    logic [3:0]   data1, data2, data3, data4;

    int n_tests = 0;
    int n_fail  = 0;
    obs_t exp_q[$];

    // Reference model: owner is -1 when the display is free; held counts cycles granted so far.
    int          m_owner;
    int          m_last;
    int          m_id;
    int          m_held;
    logic [15:0] m_data;

    display_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .val(val), .gnt(gnt), .owner_id(owner_id),
        .busy(busy), .data1(data1), .data2(data2), .data3(data3), .data4(data4)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_id    = 0;
        m_held  = 0;
        m_data  = '0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [63:0] v, output obs_t e);
        if (m_owner < 0) begin
            if (r != 0) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner;
                m_id   = m_owner;
                m_held = 1;
                m_data = v[16*m_owner +: 16];
            end
        end else begin
            logic [3:0] rest;
            rest = r & ~(4'(1) << m_owner);
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (m_held >= HOLD && rest != 0) begin
                m_owner = -1;
            end else begin
                m_held = m_held + 1;
                m_data = v[16*m_owner +: 16];
            end
        end
        e.gnt  = (m_owner < 0) ? 4'b0000 : 4'(1) << m_owner;
        e.id   = 2'(m_id);
        e.busy = (m_owner >= 0);
        e.data = m_data;
    endtask

    task automatic step(input logic [3:0] r, input logic [63:0] v);
        obs_t e;
        @(negedge clk);
        req = r;
        val = v;
        model_step(r, v, e);
        exp_q.push_back(e);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic mid_reset_check();
        obs_t got;
        @(posedge clk);
        #3;
        rst = 1'b1;
        req = '0;
        #1;
        got = {gnt, owner_id, busy, data1, data2, data3, data4};
        n_tests++;
        if (got !== 23'd0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b id=%0d busy=%b data=%h, want all zero",
                     got.gnt, got.id, got.busy, got.data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        obs_t e;
        obs_t got;
        #1;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {gnt, owner_id, busy, data1, data2, data3, data4};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got gnt=%b id=%0d busy=%b data=%h, want gnt=%b id=%0d busy=%b data=%h",
                         $time, got.gnt, got.id, got.busy, got.data, e.gnt, e.id, e.busy, e.data);
            end
        end
    end

    initial begin
        logic [63:0] v;
        logic [3:0]  r;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requester 2 with value 1234, then it drops the request.
        v = 64'h0000_1234_0000_0000;
        repeat (3) step(4'b0100, v);
        repeat (2) step(4'b0000, v);

        // Reset arrives while requester 2 holds the grant.
        step(4'b0100, v);
        step(4'b0100, v);
        mid_reset_check();

        // Full contention rotates the grant around all requesters.
        v = 64'h4444_3333_2222_1111;
        repeat (4 * (HOLD + 1) + 6) step(4'b1111, v);
        step(4'b0000, v);

        // Sole owner past its hold time, with the value changing while it owns.
        v = 64'h0000_0000_5555_0000;
        repeat (100) step(4'b0010, v);
        v[31:16] = 16'hABCD;
        repeat (2) step(4'b0010, v);
        v[31:16] = 16'h00EF;
        repeat (2) step(4'b0010, v);
        repeat (2) step(4'b0000, v);

        // Owner 0 releases early while requester 1 is waiting.
        step(4'b0001, v);
        repeat (2) step(4'b0011, v);
        repeat (3) step(4'b0010, v);
        repeat (2) step(4'b0000, v);

        // Randomized traffic: requests toggle occasionally and values drift.
        r = '0;
        v = {$urandom, $urandom};
        repeat (600) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
                if ($urandom_range(0, 3) == 0) v[16*b +: 16] = 16'($urandom);
            end
            step(r, v);
        end
        step(4'b0000, v);

        @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
